lsu: RTL and testbench

Load/store unit for the execute/memory boundary of the core. It takes the effective address from the ALU result (`a + imm` via ALU_ADD) plus the store data and load/store type, runs one word-aligned transaction on the data-memory port, and returns a sign- or zero-extended load result, or a misalignment error, to writeback. It is a single-outstanding, multi-cycle unit, and the pipeline stalls on it through a valid/ready handshake.

---
 rtl/lsu.sv | 155 +++++++++++++++
 tb/tb_lsu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between execute and data memory.
// Accepts one request in IDLE, issues one word-aligned memory beat (MEM),
// then pulses a one-cycle response (RESP). Misaligned or illegal requests
// skip the memory and respond with an error.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write, req_funct3      store/load select, RV32 width/sign encoding
//   req_addr, req_wdata        effective byte address, store data
//   resp_valid                 one-cycle response pulse
//   resp_rdata, resp_error     extended load data (0 for stores/errors), error flag
//   mem_valid/mem_ready        single-beat memory handshake
//   mem_write, mem_addr        store select, word-aligned address
//   mem_wdata, mem_wstrb       lane-replicated store data, byte enables
//   mem_rdata                  read word, sampled on mem_valid && mem_ready
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// MEM   | memory beat outstanding, mem_* held stable
// RESP  | response pulse, returns to IDLE next cycle
module lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [DATA_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_error,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_write,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t state, state_next;

  logic                    write_q;
  logic [2:0]              funct3_q;
  logic [1:0]              offset_q;

  logic                    accept;
  logic                    illegal;
  logic                    misaligned;
  logic                    req_error;
  logic                    mem_done;
  logic [DATA_WIDTH-1:0]   store_data;
  logic [DATA_WIDTH/8-1:0] store_strb;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = (state == IDLE) && req_valid;
    mem_done   = (state == MEM) && mem_ready;

    // Stores only have the three unsigned-less widths; loads add LBU/LHU.
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_write;
      default:                illegal = 1'b1;
    endcase

    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    req_error = illegal || misaligned;

    case (req_funct3[1:0])
      2'b00: begin
        store_data = {4{req_wdata[7:0]}};
        store_strb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        store_data = {2{req_wdata[15:0]}};
        store_strb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = req_wdata;
        store_strb = 4'b1111;
      end
    endcase

    shifted = mem_rdata >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    if (write_q) load_data = '0;

    case (state)
      IDLE:    if (accept) state_next = req_error ? RESP : MEM;
      MEM:     if (mem_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All outputs are registered off state_next so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
    end else begin
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      mem_valid  <= (state_next == MEM);
      resp_error <= accept && req_error;
      resp_rdata <= mem_done ? load_data : '0;
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        offset_q <= req_addr[1:0];
        if (!req_error) begin
          mem_write <= req_write;
          mem_addr  <= {req_addr[DATA_WIDTH-1:2], 2'b00};
          mem_wdata <= store_data;
          mem_wstrb <= req_write ? store_strb : 4'b0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. Directed vector table from the
// documented examples, randomized requests against a byte-lane reference
// model, and hand sequences for reset behaviour.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  lsu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    bit          err;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } vec_t;

  // results of the last transaction
  bit          r_err, r_saw_mem, r_stable, r_timeout, r_mwrite, r_mv_at_resp;
  bit          r_post_rv, r_post_rdy;
  logic [31:0] r_rdata, r_maddr, r_mwdata;
  logic [3:0]  r_strb;
  int          r_lat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Behavioural reference: access size from funct3, byte lanes by index.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       output bit err, output logic [31:0] maddr,
                       output logic [31:0] mwd, output logic [3:0] strb,
                       output logic [31:0] rdat);
    bit legal;
    int size, off;
    longint unsigned val, mask;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    off   = int'(a % 4);
    err   = !legal || (legal && (a % size) != 0);
    maddr = a - 32'(off);
    mwd   = '0;
    strb  = '0;
    rdat  = '0;
    if (!err && w) begin
      for (int i = 0; i < 4; i++) begin
        mwd[8*i +: 8] = wd[8*(i % size) +: 8];
        if (i >= off && i < off + size) strb[i] = 1'b1;
      end
    end
    if (!err && !w) begin
      val  = longint'(rd) >> (8 * off);
      mask = (64'd1 << (8 * size)) - 1;
      val  = val & mask;
      if (f3[2] == 1'b0 && val[8*size-1]) val = val | ~mask;
      rdat = val[31:0];
    end
  endtask

  task automatic run_txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int guard, mem_cycles;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_rdata = rd; mem_ready = 1'b0;
    @(posedge clk); #1;
    // scramble request inputs so any later resampling would be visible
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom); req_write = 1'($urandom);
    r_saw_mem = 0; r_stable = 1; r_timeout = 1; r_lat = 0; r_err = 0; r_rdata = '0;
    r_maddr = '0; r_mwdata = '0; r_strb = '0; r_mwrite = 0; r_mv_at_resp = 0;
    mem_cycles = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (resp_valid) begin
        r_err = resp_error; r_rdata = resp_rdata; r_lat = cyc; r_timeout = 0;
        r_mv_at_resp = mem_valid;
        req_valid = 1'b0; mem_ready = 1'b0;
        break;
      end
      if (mem_valid) begin
        if (!r_saw_mem) begin
          r_maddr = mem_addr; r_mwdata = mem_wdata; r_strb = mem_wstrb; r_mwrite = mem_write;
        end else if (mem_addr !== r_maddr || mem_wdata !== r_mwdata ||
                     mem_wstrb !== r_strb || mem_write !== r_mwrite) begin
          r_stable = 0;
        end
        r_saw_mem = 1;
        mem_cycles++;
        mem_ready = (mem_cycles > waits);
        req_valid = 1'($urandom);
      end else begin
        req_valid = 1'b0;
        mem_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    r_post_rv = resp_valid;
    r_post_rdy = req_ready;
  endtask

  task automatic compare(input string tag, input bit w, input bit err,
                         input logic [31:0] maddr, input logic [31:0] mwd,
                         input logic [3:0] strb, input logic [31:0] rdata, input int waits);
    chk({tag, " timeout"}, 32'(r_timeout), 32'd0);
    chk({tag, " resp_error"}, 32'(r_err), 32'(err));
    chk({tag, " resp_rdata"}, r_rdata, rdata);
    chk({tag, " latency"}, r_lat, err ? 32'd1 : 32'(2 + waits));
    chk({tag, " mem_seen"}, 32'(r_saw_mem), 32'(!err));
    chk({tag, " mem_valid_at_resp"}, 32'(r_mv_at_resp), 32'd0);
    if (!err) begin
      chk({tag, " mem_addr"}, r_maddr, maddr);
      chk({tag, " mem_write"}, 32'(r_mwrite), 32'(w));
      chk({tag, " mem_wstrb"}, 32'(r_strb), 32'(strb));
      if (w) chk({tag, " mem_wdata"}, r_mwdata, mwd);
      chk({tag, " mem_stable"}, 32'(r_stable), 32'd1);
    end
    chk({tag, " resp_one_cycle"}, 32'(r_post_rv), 32'd0);
    chk({tag, " ready_after"}, 32'(r_post_rdy), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    bit          m_err;
    logic [31:0] m_maddr, m_mwd, m_rdat;
    logic [3:0]  m_strb;

    //         w  f3    addr          wdata         rdata         wt err maddr         mwdata        strb     rdata
    vecs.push_back('{0, 3'd2, 32'h1000, 32'h0,        32'h8899AABB, 0, 0, 32'h1000, 32'h0,        4'b0000, 32'h8899AABB});
    vecs.push_back('{0, 3'd0, 32'h1002, 32'h0,        32'h8899AABB, 0, 0, 32'h1000, 32'h0,        4'b0000, 32'hFFFFFF99});
    vecs.push_back('{0, 3'd4, 32'h1002, 32'h0,        32'h8899AABB, 1, 0, 32'h1000, 32'h0,        4'b0000, 32'h00000099});
    vecs.push_back('{0, 3'd1, 32'h1002, 32'h0,        32'h8899AABB, 0, 0, 32'h1000, 32'h0,        4'b0000, 32'hFFFF8899});
    vecs.push_back('{0, 3'd5, 32'h1000, 32'h0,        32'h8899AABB, 2, 0, 32'h1000, 32'h0,        4'b0000, 32'h0000AABB});
    vecs.push_back('{0, 3'd0, 32'h1003, 32'h0,        32'h8899AABB, 0, 0, 32'h1000, 32'h0,        4'b0000, 32'hFFFFFF88});
    vecs.push_back('{0, 3'd1, 32'h1000, 32'h0,        32'h8899AABB, 0, 0, 32'h1000, 32'h0,        4'b0000, 32'hFFFFAABB});
    vecs.push_back('{0, 3'd4, 32'h1001, 32'h0,        32'h8899AABB, 0, 0, 32'h1000, 32'h0,        4'b0000, 32'h000000AA});
    vecs.push_back('{1, 3'd0, 32'h2003, 32'h12345678, 32'h0,        0, 0, 32'h2000, 32'h78787878, 4'b1000, 32'h0});
    vecs.push_back('{1, 3'd1, 32'h2002, 32'h12345678, 32'h0,        0, 0, 32'h2000, 32'h56785678, 4'b1100, 32'h0});
    vecs.push_back('{1, 3'd2, 32'h2004, 32'h12345678, 32'h0,        0, 0, 32'h2004, 32'h12345678, 4'b1111, 32'h0});
    vecs.push_back('{1, 3'd2, 32'h2008, 32'hCAFEF00D, 32'h0,        4, 0, 32'h2008, 32'hCAFEF00D, 4'b1111, 32'h0});
    vecs.push_back('{0, 3'd2, 32'h1001, 32'h0,        32'h8899AABB, 0, 1, 32'h0,    32'h0,        4'b0000, 32'h0});
    vecs.push_back('{1, 3'd1, 32'h0003, 32'h12345678, 32'h0,        0, 1, 32'h0,    32'h0,        4'b0000, 32'h0});
    vecs.push_back('{0, 3'd3, 32'h1000, 32'h0,        32'h8899AABB, 0, 1, 32'h0,    32'h0,        4'b0000, 32'h0});
    vecs.push_back('{1, 3'd4, 32'h1000, 32'h0,        32'h0,        0, 1, 32'h0,    32'h0,        4'b0000, 32'h0});

    // reset values
    #31;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_error", 32'(resp_error), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst req_ready after release", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_txn(v.w, v.f3, v.a, v.wd, v.rd, v.waits);
      compare($sformatf("vec%0d", i), v.w, v.err, v.maddr, v.mwd, v.strb, v.rdata, v.waits);
    end

    // reset in the middle of a memory beat
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4000;
    mem_ready = 1'b0; mem_rdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst mem_valid before", 32'(mem_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst mem_valid drops", 32'(mem_valid), 32'd0);
    chk("midrst req_ready low", 32'(req_ready), 32'd0);
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("midrst no resp_valid", 32'(resp_valid), 32'd0);
    end
    mem_ready = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst req_ready first edge", 32'(req_ready), 32'd1);
    chk("midrst resp_valid after", 32'(resp_valid), 32'd0);
    run_txn(1'b0, 3'd2, 32'h4004, 32'h0, 32'h55667788, 0);
    compare("post_rst LW", 1'b0, 1'b0, 32'h4004, 32'h0, 4'b0000, 32'h55667788, 0);

    // randomized requests against the reference model
    for (int n = 0; n < 150; n++) begin
      bit w;
      logic [2:0] f3;
      logic [31:0] a, wd, rd;
      int waits;
      w = 1'($urandom);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (w ? 3'($urandom_range(0, 2))
                                                        : 3'($urandom_range(0, 5)));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom; rd = $urandom;
      waits = $urandom_range(0, 3);
      model(w, f3, a, wd, rd, m_err, m_maddr, m_mwd, m_strb, m_rdat);
      run_txn(w, f3, a, wd, rd, waits);
      compare($sformatf("rnd%0d w%0d f3=%0d a=%08h", n, w, f3, a), w, m_err,
              m_maddr, m_mwd, m_strb, m_rdat, waits);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
